// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl: captures eight interrupt request lines into a pending
// register, masks them, and presents the highest-priority unmasked request
// (bit 7 highest) as a registered 3-bit vector over a valid/ack handshake.
// An in-service state blocks further vectors until end-of-interrupt.
module irq_vector_ctrl #(
  parameter bit EDGE_MODE = 1'b1  // 1: rising-edge capture, 0: level capture
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic [7:0] mask,
  input  logic       en,
  output logic       vec_valid,
  output logic [2:0] vec,
  input  logic       vec_ack,
  input  logic       eoi,
  output logic [7:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] irq_q;
  logic [7:0] set;
  logic [7:0] clr;
  logic [7:0] req;
  logic [7:0] pending_d;
  logic [2:0] enc;
  logic [2:0] vec_d;
  logic       vec_valid_d;
  logic       busy_d;

  // Capture terms and the masked candidate set presented to the encoder.
  always_comb begin
    set = EDGE_MODE ? (irq & ~irq_q) : irq;
    req = pending & ~mask;
  end

  // Priority encoder: ascending scan so the highest set bit is the last to win.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, otherwise paths that skip the assignment infer a latch.
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) enc = 3'(i);
    end
  end

  // Next-state logic: arbitration in IDLE, handshake in PRESENT, hold in SERVICE.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec;
    vec_valid_d = vec_valid;
    busy_d      = busy;
    clr         = 8'h00;
    unique case (state_q)
      IDLE: begin
        vec_valid_d = 1'b0;
        if (en && (req != 8'h00)) begin
          vec_d       = enc;
          vec_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        // Ack takes precedence over a simultaneous drop of en; the presented
        // vector is never re-arbitrated or withdrawn by a mask change here.
        if (vec_ack) begin
          clr         = 8'h01 << vec;
          vec_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = SERVICE;
        end else if (!en) begin
          vec_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        vec_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
    // A bit set and cleared in the same cycle stays pending: set applied last.
    pending_d = (pending & ~clr) | set;
  end

  // State and registered outputs; synchronous reset discards everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= 8'h00;
      pending   <= 8'h00;
      vec       <= 3'd0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq;
      pending   <= pending_d;
      vec       <= vec_d;
      vec_valid <= vec_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// tb_irq_vector_ctrl: directed self-checking bench. One instance runs in
// rising-edge mode, a second in level mode; both share the same stimulus.
module tb_irq_vector_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq;
  logic [7:0] mask;
  logic       en;
  logic       vec_ack;
  logic       eoi;

  logic       vec_valid, busy;
  logic [2:0] vec;
  logic [7:0] pending;
  logic       lvl_vec_valid, lvl_busy;
  logic [2:0] lvl_vec;
  logic [7:0] lvl_pending;

  int n_checks = 0;
  int n_fail   = 0;

  irq_vector_ctrl #(.EDGE_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mask(mask), .en(en),
    .vec_valid(vec_valid), .vec(vec), .vec_ack(vec_ack), .eoi(eoi),
    .pending(pending), .busy(busy)
  );

  irq_vector_ctrl #(.EDGE_MODE(1'b0)) dut_lvl (
    .clk(clk), .rst(rst), .irq(irq), .mask(mask), .en(en),
    .vec_valid(lvl_vec_valid), .vec(lvl_vec), .vec_ack(vec_ack), .eoi(eoi),
    .pending(lvl_pending), .busy(lvl_busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; mask = 8'h00; en = 1'b1; vec_ack = 1'b0; eoi = 1'b0;
    step(); step();
    chk("rst_pending", pending, 8'h00);
    chk("rst_valid", vec_valid, 8'h00);
    chk("rst_vec", vec, 8'h00);
    chk("rst_busy", busy, 8'h00);
    rst = 1'b0;

    // Single pulse on irq[4]: pending after 1 edge, vector after 2.
    irq = 8'h10; step();
    chk("t1_pending", pending, 8'h10);
    chk("t1_valid_early", vec_valid, 8'h00);
    irq = 8'h00; step();
    chk("t1_valid", vec_valid, 8'h01);
    chk("t1_vec", vec, 8'h04);
    vec_ack = 1'b1; step();
    chk("t1_ack_pending", pending, 8'h00);
    chk("t1_ack_busy", busy, 8'h01);
    chk("t1_ack_valid", vec_valid, 8'h00);
    vec_ack = 1'b0; eoi = 1'b1; step();
    chk("t1_eoi_busy", busy, 8'h00);
    eoi = 1'b0;

    // Masked bit 7 still accumulates but only bit 0 is granted.
    mask = 8'h80; irq = 8'h81; step();
    chk("t2_pending", pending, 8'h81);
    irq = 8'h00; step();
    chk("t2_vec", vec, 8'h00);
    chk("t2_valid", vec_valid, 8'h01);
    vec_ack = 1'b1; step();
    vec_ack = 1'b0; eoi = 1'b1; step();
    eoi = 1'b0; step();
    chk("t2_pending_after", pending, 8'h80);
    chk("t2_no_vector", vec_valid, 8'h00);
    chk("t2_busy", busy, 8'h00);
    rst = 1'b1; mask = 8'h00; step();
    rst = 1'b0;

    // Higher-priority arrival in PRESENT does not change the vector.
    irq = 8'h04; step();
    step();
    chk("t3_vec2", vec, 8'h02);
    irq = 8'h44; step();
    chk("t3_pending", pending, 8'h44);
    chk("t3_vec_hold", vec, 8'h02);
    step();
    chk("t3_vec_hold2", vec, 8'h02);
    vec_ack = 1'b1; step();
    chk("t3_ack_pending", pending, 8'h40);
    vec_ack = 1'b0; eoi = 1'b1; step();
    chk("t3_eoi_valid", vec_valid, 8'h00);
    chk("t3_eoi_busy", busy, 8'h00);
    eoi = 1'b0; step();
    chk("t3_vec6_valid", vec_valid, 8'h01);
    chk("t3_vec6", vec, 8'h06);
    vec_ack = 1'b1; step();
    vec_ack = 1'b0; eoi = 1'b1; step();
    eoi = 1'b0; irq = 8'h00; step();

    // Dropping en withdraws the vector but keeps the pending bit.
    irq = 8'h08; step();
    chk("t4_pending", pending, 8'h08);
    step();
    chk("t4_vec3", vec, 8'h03);
    en = 1'b0; step();
    chk("t4_en_valid", vec_valid, 8'h00);
    chk("t4_en_pending", pending, 8'h08);
    en = 1'b1; step();
    chk("t4_re_valid", vec_valid, 8'h01);
    chk("t4_re_vec", vec, 8'h03);
    // Ack wins over a simultaneous en drop.
    en = 1'b0; vec_ack = 1'b1; step();
    chk("t4_ackwin_busy", busy, 8'h01);
    chk("t4_ackwin_pending", pending, 8'h00);
    en = 1'b1; vec_ack = 1'b0; eoi = 1'b1; step();
    chk("t4_eoi_busy", busy, 8'h00);
    eoi = 1'b0; irq = 8'h00; step();

    // Reset while busy with pending 0C discards everything.
    irq = 8'h1C; step();
    irq = 8'h00; step();
    chk("t5_vec4", vec, 8'h04);
    vec_ack = 1'b1; step();
    chk("t5_pending", pending, 8'h0C);
    chk("t5_busy", busy, 8'h01);
    vec_ack = 1'b0; rst = 1'b1; step();
    chk("t5_rst_pending", pending, 8'h00);
    chk("t5_rst_busy", busy, 8'h00);
    chk("t5_rst_valid", vec_valid, 8'h00);
    chk("t5_rst_vec", vec, 8'h00);
    rst = 1'b0; step(); step();
    chk("t5_idle_valid", vec_valid, 8'h00);
    chk("t5_idle_pending", pending, 8'h00);

    // Line held through reset; level mode keeps the bit pending across ack.
    rst = 1'b1; irq = 8'h20; step();
    chk("t6_rst_pending", pending, 8'h00);
    chk("t6_rst_lvl_pending", lvl_pending, 8'h00);
    rst = 1'b0; step();
    chk("t6_edge_pending", pending, 8'h20);
    chk("t6_lvl_pending", lvl_pending, 8'h20);
    step();
    chk("t6_edge_vec", vec, 8'h05);
    chk("t6_lvl_vec", lvl_vec, 8'h05);
    chk("t6_lvl_valid", lvl_vec_valid, 8'h01);
    vec_ack = 1'b1; step();
    chk("t6_edge_ack_pending", pending, 8'h00);
    chk("t6_lvl_ack_pending", lvl_pending, 8'h20);
    chk("t6_lvl_busy", lvl_busy, 8'h01);
    vec_ack = 1'b0; eoi = 1'b1; step();
    chk("t6_lvl_eoi_busy", lvl_busy, 8'h00);
    eoi = 1'b0; step();
    chk("t6_lvl_revalid", lvl_vec_valid, 8'h01);
    chk("t6_lvl_revec", lvl_vec, 8'h05);
    chk("t6_edge_novalid", vec_valid, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
